// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register: FSM encoding and the
// EX/MEM control-bit layout callers can cast the ctrl bus to.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } pipe_state_t;

  localparam int XLEN         = 32;
  localparam int EXMEM_CTRL_W = 5;

  typedef struct packed {
    logic       mem_rw;
    logic [1:0] wb_sel;
    logic       reg_wen;
    logic       pc_sel;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and a
// 2-entry (main + skid) buffer so in_ready comes straight from a flop.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 5,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_reg;
  pipe_state_t       state_next;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;

  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (in_xfer) state_next = ST_FULL;
        ST_FULL: begin
          if (in_xfer && !out_xfer)      state_next = ST_SKID;
          else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
        end
        ST_SKID:  if (out_xfer) state_next = ST_FULL;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs decode only the state flop: nothing from out_ready reaches in_ready.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_reg)
      ST_FULL: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_SKID: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign load_main_in   = !flush && in_xfer &&
                          ((state_reg == ST_EMPTY) || ((state_reg == ST_FULL) && out_xfer));
  assign load_main_skid = !flush && (state_reg == ST_SKID) && out_xfer;
  assign load_skid      = !flush && (state_reg == ST_FULL) && in_xfer && !out_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_data_reg <= in_data;
        main_ctrl_reg <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
        main_ctrl_reg <= skid_ctrl_reg;
      end
      if (load_skid) begin
        skid_data_reg <= in_data;
        skid_ctrl_reg <= in_ctrl;
      end
    end
  end

  assign out_data = main_data_reg;
  assign out_ctrl = out_valid ? main_ctrl_reg : CTRL_NOP;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scenario bench for pipe_skid_stage: a negedge monitor scoreboards every
// accepted input against every emitted output; tasks add inline state checks.
module tb_pipe_skid_stage;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } item_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int    errors = 0;
  int    checks = 0;
  int    popped = 0;
  item_t sb[$];
  item_t mon_exp;

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP('0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so at negedge they are stable for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got data=%0h ctrl=%b, required no transfer", out_data, out_ctrl);
        end else begin
          mon_exp = sb.pop_front();
          popped++;
          if (out_data !== mon_exp.d || out_ctrl !== mon_exp.c) begin
            errors++;
            $display("FAIL out_order: got data=%0h ctrl=%b, required data=%0h ctrl=%b",
                     out_data, out_ctrl, mon_exp.d, mon_exp.c);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{d: in_data, c: in_ctrl});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_ctrl !== 5'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%b occ=%0d ctrl=%b data=%0h, required v=0 r=1 occ=0 ctrl=0 data=0",
               out_valid, in_ready, occupancy, out_ctrl, out_data);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 128'h1; vals[1] = 128'h2; vals[2] = 128'h3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], CTRL_W'(i + 3));
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1 || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b data=%0h r=%b occ=%0d, required v=1 data=%0h r=1 occ=1",
                 i, out_valid, out_data, in_ready, occupancy, vals[i]);
      end
    end
    drive(1'b0, '0, '0);
    cycle();
    cycle();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got occ=%0d v=%b, required occ=0 v=0", occupancy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int start_pop;
    start_pop = popped;
    out_ready = 1'b0;
    drive(1'b1, 128'h11, 5'h01);
    cycle();
    drive(1'b1, 128'h22, 5'h02);
    cycle();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d r=%b, required occ=2 r=0", occupancy, in_ready);
    end
    drive(1'b1, 128'h33, 5'h03);
    cycle();
    checks++;
    if (occupancy !== 2'd2 || out_data !== 128'h11 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold_c: got occ=%0d data=%0h r=%b, required occ=2 data=11 r=0",
               occupancy, out_data, in_ready);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (in_ready !== 1'b1 || out_data !== 128'h22) begin
      errors++;
      $display("FAIL bp_release: got r=%b data=%0h, required r=1 data=22", in_ready, out_data);
    end
    cycle();
    drive(1'b0, '0, '0);
    cycle();
    cycle();
    checks++;
    if (popped - start_pop !== 3 || sb.size() !== 0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_count: got emitted=%0d pending=%0d occ=%0d, required emitted=3 pending=0 occ=0",
               popped - start_pop, sb.size(), occupancy);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    drive(1'b1, 128'hDEAD, 5'h0A);
    cycle();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 128'hDEAD || out_ctrl !== 5'h0A) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b data=%0h ctrl=%b, required v=1 data=dead ctrl=01010",
                 i, out_valid, out_data, out_ctrl);
      end
      cycle();
    end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 128'h77, 5'h07);
    cycle();
    drive(1'b1, 128'h88, 5'h08);
    cycle();
    flush = 1'b1;
    drive(1'b1, 128'h44, 5'h04);
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 5'd0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid: got v=%b ctrl=%b occ=%0d r=%b, required v=0 ctrl=0 occ=0 r=1",
               out_valid, out_ctrl, occupancy, in_ready);
    end
    // From ST_FULL in_ready is high, so the offered word must be dropped by flush itself.
    drive(1'b1, 128'h90, 5'h09);
    cycle();
    flush = 1'b1;
    drive(1'b1, 128'h45, 5'h05);
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL flush_full_%0d: got v=%b data=%0h occ=%0d, required v=0 occ=0",
                 i, out_valid, out_data, occupancy);
      end
      cycle();
    end
  endtask

  task automatic test_ctrl_mask();
    out_ready = 1'b0;
    drive(1'b1, 128'hC0, 5'b11111);
    #1;
    checks++;
    if (out_ctrl !== 5'd0) begin
      errors++;
      $display("FAIL ctrl_empty: got %b, required 00000", out_ctrl);
    end
    cycle();
    drive(1'b0, '0, '0);
    checks++;
    if (out_ctrl !== 5'b11111) begin
      errors++;
      $display("FAIL ctrl_loaded: got %b, required 11111", out_ctrl);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_ctrl !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_drained: got ctrl=%b v=%b, required ctrl=0 v=0", out_ctrl, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 128'hA1, 5'h11);
    cycle();
    drive(1'b1, 128'hA2, 5'h12);
    cycle();
    drive(1'b0, '0, '0);
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL arst_fill: got occ=%0d, required 2", occupancy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL arst_immediate: got v=%b r=%b occ=%0d, required v=0 r=1 occ=0",
               out_valid, in_ready, occupancy);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(1'b1, 128'h55, 5'h15);
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 128'h55) begin
      errors++;
      $display("FAIL arst_after_a: got v=%b data=%0h, required v=1 data=55", out_valid, out_data);
    end
    drive(1'b1, 128'h66, 5'h16);
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 128'h66) begin
      errors++;
      $display("FAIL arst_after_b: got v=%b data=%0h, required v=1 data=66", out_valid, out_data);
    end
    drive(1'b0, '0, '0);
    cycle();
    cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_ctrl_mask();
    test_async_reset();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL final_pending: got %0d outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic pipeline-stage register for the RV32I core. It is the next generation of the fixed EX/MEM-style latch.
- Carries a generic data payload plus control bits with a valid/ready handshake, stall back-pressure, synchronous flush (bubble insertion) and a 2-entry skid buffer, so in_ready is registered.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 128, payload width (e.g. PC, ALU result, rs2, INST = 4x32).
- CTRL_W, 5, control-bit width (e.g. MemRW, WBSel[1:0], RegWEn, PCSel); forced to 0 when the stage holds a bubble.
- CTRL_NOP, 0, CTRL_W-wide value driven on out_ctrl when out_valid=0.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- flush, in, 1, synchronous kill of all held entries.
- in_valid, in, 1, upstream has a transfer.
- in_ready, out, 1, stage can accept; registered (equals !skid_valid).
- in_data, in, DATA_W, upstream payload.
- in_ctrl, in, CTRL_W, upstream control bits.
- out_valid, out, 1, main entry holds a valid transfer.
- out_ready, in, 1, downstream accepts.
- out_data, out, DATA_W, main entry payload.
- out_ctrl, out, CTRL_W, main entry control; CTRL_NOP when !out_valid.
- occupancy, out, 2, entries held (0..2), for debug and perf counters.

Behaviour:
- Reset is asynchronous and active-high.
  - State ST_EMPTY; main and skid data/ctrl registers = 0.
  - out_valid=0, out_ctrl=CTRL_NOP, in_ready=1, occupancy=0.
  - Inputs are ignored while rst=1. A reset mid-transfer drops all held entries.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - While out_valid=1 & out_ready=0, out_data and out_ctrl are held stable, and out_valid does not drop except on flush or rst.
- FSM (state register drives out_valid, in_ready and occupancy directly):
  - ST_EMPTY:
    - in_ready=1, out_valid=0.
    - Input transfer: main <= in, go to ST_FULL.
  - ST_FULL:
    - in_ready=1, out_valid=1.
    - Input and output transfer: main <= in, stay in ST_FULL.
    - Input transfer only: skid <= in, go to ST_SKID.
    - Output transfer only: go to ST_EMPTY.
    - Neither: hold.
  - ST_SKID:
    - in_ready=0, out_valid=1.
    - Output transfer: main <= skid, go to ST_FULL.
    - Otherwise hold.
- Flush has the highest priority.
  - Next state is ST_EMPTY, and any input offered in the same cycle is discarded.
  - Any output transfer in the flush cycle still counts as completed.
  - Data registers need not be cleared.
- Latency and throughput:
  - From ST_EMPTY, 1 cycle from input transfer to out_valid.
  - Full throughput of 1 transfer per cycle with out_ready held high. No combinational path from out_ready to in_ready.
- Ordering: strict FIFO; a skid entry always leaves after the main entry.
- out_ctrl = out_valid ? main_ctrl : CTRL_NOP. out_data is unmasked.
- occupancy: ST_EMPTY=0, ST_FULL=1, ST_SKID=2.
- The encoding value 2'b11 is illegal and recovers to ST_EMPTY.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t.
  - Localparams XLEN=32, EXMEM_CTRL_W=5.
  - Packed struct ex_mem_ctrl_t {MemRW, WBSel[1:0], RegWEn, PCSel} so callers can cast in_ctrl.
- Single module; no sub-module is warranted. The skid and main entries are plain register pairs inside it.

Test Plan:
- Reset then stream A=0x1, B=0x2, C=0x3 with out_ready=1 -> outputs A,B,C on consecutive cycles, each 1 cycle after its input; in_ready stays 1; occupancy 1.
- Send A=0x11, B=0x22 with out_ready=0 -> after B, occupancy=2 and in_ready=0; C=0x33 held on input is not accepted. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Hold out_ready=0 for 5 cycles with A=0xDEAD in main -> out_data stays 0xDEAD and out_valid stays 1 throughout.
- Fill to ST_SKID, then assert flush with in_valid=1 (D=0x44) -> next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, in_ready=1; D never appears.
- in_ctrl=5'b11111 with stage empty -> out_ctrl=0. After the transfer, out_ctrl=5'b11111; after drain, out_ctrl returns to 0.
- Assert rst asynchronously mid-cycle while in ST_SKID -> out_valid=0 immediately (before the next clk edge), in_ready=1; after release, a new stream of 0x55, 0x66 passes correctly.
